// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and centre-of-bit sampling.
// Bit timing comes from an internal counter derived from CLK_FREQ/BAUD_RATE.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_CNT = BIT_CNT / 2;
  // Counter must be at least 14 bits and wide enough for BIT_CNT-1.
  localparam int unsigned CNT_W    = ($clog2(BIT_CNT) > 14) ? $clog2(BIT_CNT) : 14;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_clr;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_rx_data;
  logic [7:0]       w_rx_data_nxt;
  logic             r_rx_valid;
  logic             w_rx_valid_nxt;
  logic             r_frame_err;
  logic             w_frame_err_nxt;
  logic             r_rx_s1;
  logic             r_rx_s;

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s  <= r_rx_s1;
    end
  end

  // Receiver state, counters, shift register and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state logic: sample start at half bit, data/stop at each full bit after that.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_cnt_clr       = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (!r_rx_s) begin
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (r_cnt == HALF_LAST) begin
          if (!r_rx_s) begin
            w_state_nxt   = StData;
            w_bit_idx_nxt = 3'd0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            w_state_nxt = StIdle;
          end
        end
      end
      StData: begin
        if (r_cnt == BIT_LAST) begin
          // Restart the bit period even when staying in this state.
          w_cnt_clr   = 1'b1;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (r_cnt == BIT_LAST) begin
          if (r_rx_s) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = StIdle;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold off until the line is released so a stuck-low line cannot retrigger.
        if (r_rx_s) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    w_cnt_nxt = (w_cnt_clr || (w_state_nxt != r_state)) ? '0 : r_cnt + 1'b1;
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with a reduced bit period and randomized frames.
module tb_uart_rx;

  localparam int unsigned CLK_FREQ  = 5_000_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int          BIT       = 50;
  localparam int          HALF      = 25;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit          ferr;
    logic [7:0]  data;
    int unsigned cyc;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc   = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  hold  = 8'h00;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Issue one 8N1 frame at the given bit period; the outcome and the cycle at which the DUT
  // must report it (stop sampled HALF + 9 bits after the synchronized start) go to the queue.
  task automatic send_frame(input logic [7:0] b, input int per, input bit stop_hi);
    ev_t e;
    e.ferr = !stop_hi;
    e.data = b;
    e.cyc  = cyc + 3 + HALF + 9 * BIT;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(per);
    end
    rx = stop_hi;
    wait_cyc(per);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && k < 20 * BIT) begin
      wait_cyc(1);
      k++;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pop the scoreboard whenever the DUT strobes an outcome.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 8'h00;
      end else if (rx_valid || frame_err) begin
        check("exclusive_pulses", 32'(rx_valid & frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_pulse: actual valid=%0b ferr=%0b data=0x%0h, required none",
                   rx_valid, frame_err, rx_data);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_ferr", 32'(frame_err), 32'(e.ferr));
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (!e.ferr) begin
            hold = e.data;
          end
          check("rx_data", 32'(rx_data), 32'(hold));
        end
      end
    end
  end

  initial begin
    #(95_000 * 10);
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] dir [4];
    logic [7:0] rb;
    logic [7:0] b99;
    int         per;
    bit         ok;

    dir = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    // Plain frames.
    for (int i = 0; i < 4; i++) begin
      send_frame(dir[i], BIT, 1'b1);
      wait_cyc(BIT);
      drain("single_frame");
    end

    // Back-to-back frames, no idle gap.
    send_frame(8'h12, BIT, 1'b1);
    send_frame(8'h34, BIT, 1'b1);
    wait_cyc(BIT);
    drain("back_to_back");

    // Short glitch must not produce any output.
    rx = 1'b0;
    wait_cyc(10);
    rx = 1'b1;
    check("glitch_busy_high", 32'(busy), 32'd1);
    wait_cyc(25);
    check("glitch_busy_low", 32'(busy), 32'd0);
    wait_cyc(BIT);
    send_frame(8'h7E, BIT, 1'b1);
    wait_cyc(BIT);
    drain("after_glitch");

    // Framing error keeps the previous good byte.
    send_frame(8'h5A, BIT, 1'b1);
    send_frame(8'hC3, BIT, 1'b0);
    wait_cyc(3 * BIT);
    check("ferr_busy_while_low", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cyc(BIT);
    drain("after_ferr");
    send_frame(8'h81, BIT, 1'b1);
    wait_cyc(BIT);
    drain("recover_ferr");

    // Long break: one error, then busy drops 3 cycles after release.
    send_frame(8'h00, BIT, 1'b0);
    wait_cyc(30 * BIT);
    check("break_busy_held", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cyc(2);
    check("break_busy_2cyc", 32'(busy), 32'd1);
    wait_cyc(1);
    check("break_busy_3cyc", 32'(busy), 32'd0);
    wait_cyc(BIT);
    drain("after_break");

    // Reset during data bit 4 of 0x99: frame is abandoned.
    b99 = 8'h99;
    rx  = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b99[i];
      wait_cyc(BIT);
    end
    rx = b99[4];
    wait_cyc(BIT / 2);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(1);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    check("midreset_rx_valid", 32'(rx_valid), 32'd0);
    check("midreset_frame_err", 32'(frame_err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_cyc(2 * BIT);
    drain("after_reset");
    send_frame(8'h3C, BIT, 1'b1);
    wait_cyc(BIT);
    drain("post_reset_frame");

    // Randomized frames with +/-4% sender baud error and occasional bad stop bits.
    for (int n = 0; n < 50; n++) begin
      rb  = 8'($urandom_range(0, 255));
      per = BIT - 2 + 2 * int'($urandom_range(0, 2));
      ok  = ($urandom_range(0, 7) != 0);
      send_frame(rb, per, ok);
      if (!ok) begin
        wait_cyc(int'($urandom_range(0, 100)));
        rx = 1'b1;
        wait_cyc(BIT);
      end else begin
        wait_cyc(int'($urandom_range(0, 2)) * (per / 2));
      end
    end
    rx = 1'b1;
    wait_cyc(2 * BIT);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the Basketball design: it recovers 8N1 serial frames from an asynchronous `rx` pin and presents each received byte to the core as a one-cycle strobe. It is the receive-side counterpart of the baud-rate divider that clocks the transmit path. It shares the same 100 MHz system clock and the same `CLK_FREQ/BAUD_RATE` divisor arithmetic. Bit timing is generated internally from a free-running bit counter, not from an external tick.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate.
- Derived, not overridable: `BIT_CNT = CLK_FREQ/BAUD_RATE` (integer division; 10416 at defaults) and `HALF_CNT = BIT_CNT/2` (5208).

Ports:
- `clk` in 1: system clock; the block has a single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idles high.
- `rx_data` out 8: last correctly framed byte; holds its value until the next good frame.
- `rx_valid` out 1: one-cycle pulse when `rx_data` has just been updated.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `busy` out 1: high in every state except IDLE.

## Operation
- Input synchronizer: two flip-flops, `rx` -> `rx_s1` -> `rx_s`. Both reset to 1. All decisions use `rx_s` only.
- Bit counter `cnt`: 14 bits minimum, and it must hold `BIT_CNT-1`. It clears on every state change and increments by one each cycle otherwise.
- `bit_idx`: 3 bits. `shift`: 8 bits. Data is received LSB first and shifted in from the MSB side, so `shift <= {rx_s, shift[7:1]}`.
- States:
  - IDLE: when `rx_s==0`, go to START with `cnt=0`.
  - START: when `cnt==HALF_CNT-1`, sample `rx_s`.
    - If it is 0, go to DATA with `bit_idx=0`.
    - If it is 1, the low was a glitch: return to IDLE with no output.
  - DATA: when `cnt==BIT_CNT-1`, shift `rx_s` into `shift`.
    - If `bit_idx==7`, go to STOP.
    - Otherwise increment `bit_idx`.
  - STOP: when `cnt==BIT_CNT-1`, sample `rx_s`.
    - If it is 1: load `rx_data<=shift`, pulse `rx_valid`, go to IDLE.
    - If it is 0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. This prevents a held-low line from retriggering frames.
- After a good frame the block returns to IDLE at mid-stop-bit. A start bit that follows immediately is therefore detected without loss.
- `rx_valid` and `frame_err` are never high in the same cycle.
- Reset is honoured in any state, including mid-frame:
  - state returns to IDLE;
  - the counters clear;
  - the synchronizer flip-flops are set to 1.

## Timing
- Reset values:
  - `rx_data=8'h00`, `rx_valid=0`, `frame_err=0`, `busy=0`.
  - state IDLE, `cnt=0`, `bit_idx=0`, `shift=8'h00`.
- Let t0 be the clock edge at which `rx_s1` first captures 0. Then:
  - `rx_s` is 0 after edge t0+1.
  - IDLE->START occurs at edge t0+2.
  - The start bit is sampled at edge t0+2+`HALF_CNT`.
  - Data bit k is sampled at edge t0+2+`HALF_CNT`+(k+1)·`BIT_CNT`.
  - The stop bit is sampled at edge t0+2+`HALF_CNT`+9·`BIT_CNT`. At defaults this is t0+98954.
- `rx_valid` or `frame_err` is high for exactly the cycle following the stop-sample edge. `rx_data` changes on that same edge.
- `busy` rises the cycle after IDLE->START. It falls on the stop-sample edge (good frame) or on BREAK exit.
- Tolerance: sampling is at bit centre, so up to about ±4% cumulative baud mismatch over 10 bits must be received correctly.

## Test plan
- Defaults, reset released, send 0x55 (8N1, 10416 clk/bit): exactly one `rx_valid` pulse with `rx_data=0x55`, `frame_err` never high, `busy` low afterwards. Repeat with 0xA3, 0x00 and 0xFF.
- Back-to-back frames 0x12 then 0x34 with no idle gap: two `rx_valid` pulses spaced 10·`BIT_CNT` cycles apart (±1), giving 0x12 then 0x34.
- Glitch: `rx` low for 2000 cycles, then high: no `rx_valid`, no `frame_err`, back in IDLE (`busy=0`) by cycle ~5212. A following 0x7E frame is received correctly.
- Stop bit forced low after data 0xC3, with a prior good byte 0x5A: one `frame_err` pulse, `rx_data` stays 0x5A, `busy` stays high while `rx` is low. After `rx` returns high, 0x81 is received correctly.
- Break: `rx` held low for 300000 cycles: exactly one `frame_err` and no further pulses. `busy` drops 3 cycles after `rx` rises.
- Reset mid-frame: assert `rst` for one cycle during data bit 4 of 0x99. All outputs take their reset values and no pulse is produced for that frame. The next frame, 0x3C, gives `rx_data=0x3C`.
